// File: rtl/iomem_mailbox.sv
// Memory-mapped TX/RX word mailbox on a picorv32-style iomem bus, with sticky
// error flags and STATUS. Define IOMEM_MAILBOX_IRQ_EN to build IRQ_EN and irq.
module iomem_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] rx_data,
  output logic        irq
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  state_t        r_state;
  logic          r_ready;
  logic [31:0]   r_rdata;
  logic [31:0]   r_tx_mem [DEPTH];
  logic [31:0]   r_rx_mem [DEPTH];
  logic [AW-1:0] r_tx_wptr;
  logic [AW-1:0] r_tx_rptr;
  logic [AW-1:0] r_rx_wptr;
  logic [AW-1:0] r_rx_rptr;
  logic [CW-1:0] r_tx_count;
  logic [CW-1:0] r_rx_count;
  logic          r_ovf;
  logic          r_unf;
  logic          r_irq;

  logic          w_hit;
  logic          w_req;
  logic          w_wr;
  logic [7:0]    w_off;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_tx_pop;
  logic          w_tx_wr_req;
  logic          w_tx_push;
  logic          w_tx_ovf;
  logic          w_rx_push;
  logic          w_rx_rd_req;
  logic          w_rx_pop;
  logic          w_rx_unf;
  logic          w_st_wr;
  logic [1:0]    w_irq_en;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_val;

  assign w_hit  = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign w_req  = (r_state == ST_IDLE) && w_hit;
  assign w_wr   = (iomem_wstrb != 4'h0);
  assign w_off  = iomem_addr[7:0];

  assign w_tx_full  = (r_tx_count == FULL_CNT);
  assign w_tx_empty = (r_tx_count == {CW{1'b0}});
  assign w_rx_full  = (r_rx_count == FULL_CNT);
  assign w_rx_empty = (r_rx_count == {CW{1'b0}});

  assign tx_valid = !w_tx_empty;
  assign tx_data  = r_tx_mem[r_tx_rptr];
  assign rx_ready = !w_rx_full;

  // A full TX FIFO still takes a CPU word when the stream drains one in the same cycle.
  assign w_tx_pop    = tx_valid && tx_ready;
  assign w_tx_wr_req = w_req && w_wr && (w_off == 8'h00);
  assign w_tx_push   = w_tx_wr_req && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf    = w_tx_wr_req && w_tx_full && !w_tx_pop;

  assign w_rx_push   = rx_valid && rx_ready;
  assign w_rx_rd_req = w_req && !w_wr && (w_off == 8'h04);
  assign w_rx_pop    = w_rx_rd_req && !w_rx_empty;
  assign w_rx_unf    = w_rx_rd_req && w_rx_empty;
  assign w_st_wr     = w_req && w_wr && (w_off == 8'h08);

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_irq;

`ifdef IOMEM_MAILBOX_IRQ_EN
  logic [1:0] r_irq_en;

  // Interrupt enable register, byte lane 0 only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en <= 2'b00;
    end else if (w_req && w_wr && (w_off == 8'h0C) && iomem_wstrb[0]) begin
      r_irq_en <= iomem_wdata[1:0];
    end else begin
      r_irq_en <= r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
`else
  assign w_irq_en = 2'b00;
`endif

  // STATUS word assembled from live FIFO state and sticky flags
  always_comb begin
    w_status        = 32'h0000_0000;
    w_status[0]     = w_tx_full;
    w_status[1]     = w_tx_empty;
    w_status[2]     = w_rx_full;
    w_status[3]     = w_rx_empty;
    w_status[4]     = r_ovf;
    w_status[5]     = r_unf;
    w_status[12:8]  = 5'(r_tx_count);
    w_status[20:16] = 5'(r_rx_count);
  end

  // Read-data mux, sampled into r_rdata on the accepting edge
  always_comb begin
    w_rd_val = 32'h0000_0000;
    if (w_wr) begin
      w_rd_val = 32'h0000_0000;
    end else begin
      case (w_off)
        8'h04:   w_rd_val = w_rx_empty ? 32'h0000_0000 : r_rx_mem[r_rx_rptr];
        8'h08:   w_rd_val = w_status;
        8'h0C:   w_rd_val = {30'h0000_0000, w_irq_en};
        default: w_rd_val = 32'h0000_0000;
      endcase
    end
  end

  // Bus handshake FSM: one-cycle ACK per accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_state <= ST_ACK;
            r_ready <= 1'b1;
            r_rdata <= w_rd_val;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_rdata <= 32'h0000_0000;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_rdata <= 32'h0000_0000;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_rdata <= 32'h0000_0000;
        end
      endcase
    end
  end

  // FIFO storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr] <= iomem_wdata;
    end
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr] <= rx_data;
    end
  end

  // TX pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + CNT_ONE;
        2'b01:   r_tx_count <= r_tx_count - CNT_ONE;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // RX pointers and occupancy; an underflowing read leaves them alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + CNT_ONE;
        2'b01:   r_rx_count <= r_rx_count - CNT_ONE;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // Sticky error flags (write-1-to-clear) and registered interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_tx_ovf) begin
        r_ovf <= 1'b1;
      end else if (w_st_wr && iomem_wdata[4]) begin
        r_ovf <= 1'b0;
      end
      if (w_rx_unf) begin
        r_unf <= 1'b1;
      end else if (w_st_wr && iomem_wdata[5]) begin
        r_unf <= 1'b0;
      end
      r_irq <= (w_irq_en[0] && !w_rx_empty) || (w_irq_en[1] && w_tx_empty);
    end
  end

endmodule
